// File: rtl/b2w_pkg.sv
// b2w_pkg: shared types and constants for the byte-to-word receiver.
// Holds the FSM state encoding, the word geometry and the width helper
// for the optional inter-byte timeout counter (see B2W_TIMEOUT_EN).
package b2w_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = WORD_BYTES * 8;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    // Counter width able to hold 0..cycles.
    function automatic int timeout_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/b2w_timeout.sv
// b2w_timeout: idle-cycle counter for a partially assembled word.
// Counts while enabled, restarts on clear, and flags expiry on the cycle
// the count would reach TIMEOUT_CYCLES. A clear in the same cycle
// suppresses expiry, so an arriving byte always wins over the timeout.
module b2w_timeout
    import b2w_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_expire = i_en && !i_clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next count: held at zero outside collection, restart on every byte.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en || o_expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/byte_to_word_rx.sv
// byte_to_word_rx: UART byte stream to byte pass-through or 32-bit word.
// Mode is sampled on the first byte only; words are assembled MSB first and
// published on o_word one cycle after the fourth byte. Defining
// B2W_TIMEOUT_EN adds an inter-byte idle timeout that discards a stalled
// partial word; without it a partial word waits forever.
module byte_to_word_rx
    import b2w_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              sys_clk,
    input  logic              sw_0,
    input  logic              i_mode_select,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic [7:0]        o_byte,
    output logic              o_byte_valid,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic              o_busy,
    output logic              o_timeout_err
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] part_q, part_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_vld_q, byte_vld_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] part_ins;
    logic              expire;

`ifdef B2W_TIMEOUT_EN
    b2w_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (sys_clk),
        .rst_n    (sw_0),
        .i_en     (state_q == S_COLLECT),
        .i_clr    (i_rx_dv),
        .o_expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign o_byte        = byte_q;
    assign o_byte_valid  = byte_vld_q;
    assign o_word        = word_q;
    assign o_word_valid  = word_vld_q;
    assign o_busy        = (state_q == S_COLLECT);
    // err_q is constant zero when the timeout feature is not built.
    assign o_timeout_err = err_q;

    // Partial word with the incoming byte placed at the current index.
    always_comb begin
        part_ins = part_q;
        part_ins[(WORD_BYTES - 1 - int'(idx_q)) * 8 +: 8] = i_rx_byte;
    end

    // FSM next-state and output staging; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        part_d     = part_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        word_d     = word_q;
        word_vld_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rx_dv) begin
                    if (!i_mode_select) begin
                        byte_d     = i_rx_byte;
                        byte_vld_d = 1'b1;
                    end else begin
                        part_d  = {i_rx_byte, {(WORD_W-8){1'b0}}};
                        idx_d   = IDX_W'(1);
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (i_rx_dv) begin
                    if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                        word_d     = part_ins;
                        word_vld_d = 1'b1;
                        part_d     = '0;
                        idx_d      = '0;
                        state_d    = S_IDLE;
                    end else begin
                        part_d = part_ins;
                        idx_d  = idx_q + 1'b1;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    part_d  = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial word silently.
    always_ff @(posedge sys_clk or negedge sw_0) begin
        if (!sw_0) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            part_q     <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            part_q     <= part_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_byte_to_word_rx.sv
// tb_byte_to_word_rx: scoreboard bench for byte_to_word_rx.
// Expected bytes/words are queued when stimulus is driven and popped by a
// monitor on each valid pulse. Timeout scenarios run when B2W_TIMEOUT_EN
// is defined; otherwise the bench checks that a partial word waits forever.
module tb_byte_to_word_rx;

    localparam int TO = 16;

    logic        sys_clk = 1'b0;
    logic        sw_0;
    logic        i_mode_select;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        o_busy;
    logic        o_timeout_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];

    byte_to_word_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk       (sys_clk),
        .sw_0          (sw_0),
        .i_mode_select (i_mode_select),
        .i_rx_dv       (i_rx_dv),
        .i_rx_byte     (i_rx_byte),
        .o_byte        (o_byte),
        .o_byte_valid  (o_byte_valid),
        .o_word        (o_word),
        .o_word_valid  (o_word_valid),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: pop and compare on every valid pulse, count error pulses.
    always @(negedge sys_clk) begin
        if (sw_0) begin
            if (o_byte_valid) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected got %02h required none", o_byte);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    if (o_byte !== eb) begin
                        errors++;
                        $display("FAIL byte_value got %02h required %02h", o_byte, eb);
                    end
                end
            end
            if (o_word_valid) begin
                checks++;
                if (exp_words.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected got %08h required none", o_word);
                end else begin
                    logic [31:0] ew;
                    ew = exp_words.pop_front();
                    if (o_word !== ew) begin
                        errors++;
                        $display("FAIL word_value got %08h required %08h", o_word, ew);
                    end
                end
            end
            if (o_timeout_err) err_seen++;
        end
    end

    task automatic strobe(input logic [7:0] b, input logic m);
        @(negedge sys_clk);
        i_rx_dv       = 1'b1;
        i_rx_byte     = b;
        i_mode_select = m;
    endtask

    task automatic idle_n(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            i_rx_dv = 1'b0;
        end
    endtask

    task automatic test_reset;
        sw_0 = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_mode_select = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({o_byte, o_byte_valid, o_word, o_word_valid, o_busy, o_timeout_err} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h %b %h %b %b %b required all zero",
                     o_byte, o_byte_valid, o_word, o_word_valid, o_busy, o_timeout_err);
        end
        sw_0 = 1'b1;
        idle_n(2);
    endtask

    task automatic test_byte_pass;
        exp_bytes.push_back(8'hAB);
        strobe(8'hAB, 1'b0);
        idle_n(1);
        checks++;
        if (o_byte_valid !== 1'b1 || o_word_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL byte_latency got bv=%b wv=%b busy=%b required 1 0 0",
                     o_byte_valid, o_word_valid, o_busy);
        end
        idle_n(1);
        checks++;
        if (o_byte_valid !== 1'b0 || o_byte !== 8'hAB || o_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL byte_hold got bv=%b byte=%02h wv=%b required 0 ab 0",
                     o_byte_valid, o_byte, o_word_valid);
        end
        exp_bytes.push_back(8'h00);
        strobe(8'h00, 1'b0);
        idle_n(2);
        checks++;
        if (o_byte !== 8'h00) begin
            errors++;
            $display("FAIL byte_zero got %02h required 00", o_byte);
        end
    endtask

    task automatic test_word;
        logic [31:0] w;
        w = 32'h00FF12CD;
        exp_words.push_back(w);
        for (int i = 0; i < 4; i++) begin
            strobe(w[31-8*i -: 8], 1'b1);
            idle_n(1);
            checks++;
            if (i < 3) begin
                if (o_busy !== 1'b1 || o_word_valid !== 1'b0 || o_word !== 32'h0) begin
                    errors++;
                    $display("FAIL word_partial[%0d] got busy=%b wv=%b word=%08h required 1 0 00000000",
                             i, o_busy, o_word_valid, o_word);
                end
            end else begin
                if (o_busy !== 1'b0 || o_word_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL word_done got busy=%b wv=%b required 0 1", o_busy, o_word_valid);
                end
            end
        end
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b0 || o_word !== w) begin
            errors++;
            $display("FAIL word_hold got wv=%b word=%08h required 0 %08h", o_word_valid, o_word, w);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w1, w2;
        w1 = 32'h88776655;
        w2 = 32'h01800AF0;
        exp_words.push_back(w1);
        exp_words.push_back(w2);
        for (int i = 0; i < 4; i++) strobe(w1[31-8*i -: 8], (i == 0) ? 1'b1 : 1'($urandom_range(1)));
        for (int i = 0; i < 4; i++) strobe(w2[31-8*i -: 8], (i == 0) ? 1'b1 : 1'($urandom_range(1)));
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_bytes.push_back(b);
            strobe(b, 1'b0);
        end
        idle_n(3);
        checks++;
        if (exp_words.size() != 0 || exp_bytes.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got words=%0d bytes=%0d pending required 0 0",
                     exp_words.size(), exp_bytes.size());
        end
    endtask

    task automatic test_mode_toggle;
        exp_words.push_back(32'hDEADBEEF);
        strobe(8'hDE, 1'b1);
        strobe(8'hAD, 1'b0);
        strobe(8'hBE, 1'b0);
        strobe(8'hEF, 1'b0);
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b1 || o_word !== 32'hDEADBEEF || o_byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_word got wv=%b word=%08h bv=%b required 1 deadbeef 0",
                     o_word_valid, o_word, o_byte_valid);
        end
        exp_bytes.push_back(8'h10);
        strobe(8'h10, 1'b0);
        idle_n(1);
        checks++;
        if (o_byte_valid !== 1'b1 || o_byte !== 8'h10) begin
            errors++;
            $display("FAIL toggle_byte got bv=%b byte=%02h required 1 10", o_byte_valid, o_byte);
        end
    endtask

    task automatic test_reset_mid_word;
        int e0;
        e0 = err_seen;
        strobe(8'h5A, 1'b1);
        strobe(8'h5B, 1'b1);
        @(negedge sys_clk);
        i_rx_dv = 1'b0;
        sw_0 = 1'b0;
        #1;
        checks++;
        if ({o_byte, o_byte_valid, o_word, o_word_valid, o_busy, o_timeout_err} !== 44'd0) begin
            errors++;
            $display("FAIL reset_mid_word got %h %b %h %b %b %b required all zero",
                     o_byte, o_byte_valid, o_word, o_word_valid, o_busy, o_timeout_err);
        end
        @(negedge sys_clk);
        sw_0 = 1'b1;
        exp_words.push_back(32'hAABBCCDD);
        strobe(8'hAA, 1'b1);
        strobe(8'hBB, 1'b1);
        strobe(8'hCC, 1'b1);
        strobe(8'hDD, 1'b1);
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b1 || o_word !== 32'hAABBCCDD || err_seen != e0) begin
            errors++;
            $display("FAIL reset_then_word got wv=%b word=%08h errs=%0d required 1 aabbccdd 0",
                     o_word_valid, o_word, err_seen - e0);
        end
        idle_n(1);
    endtask

`ifdef B2W_TIMEOUT_EN
    task automatic test_timeout;
        int e0;
        e0 = err_seen;
        strobe(8'h11, 1'b1);
        strobe(8'h22, 1'b1);
        idle_n(TO);
        checks++;
        if (o_busy !== 1'b1 || err_seen != e0) begin
            errors++;
            $display("FAIL timeout_early got busy=%b errs=%0d required 1 0", o_busy, err_seen - e0);
        end
        idle_n(1);
        checks++;
        if (o_timeout_err !== 1'b1 || o_busy !== 1'b0 || o_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got err=%b busy=%b wv=%b required 1 0 0",
                     o_timeout_err, o_busy, o_word_valid);
        end
        idle_n(3);
        checks++;
        if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL timeout_count got %0d required 1", err_seen - e0);
        end
        exp_words.push_back(32'h01020304);
        strobe(8'h01, 1'b1);
        strobe(8'h02, 1'b1);
        strobe(8'h03, 1'b1);
        strobe(8'h04, 1'b1);
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b1 || o_word !== 32'h01020304) begin
            errors++;
            $display("FAIL timeout_recover got wv=%b word=%08h required 1 01020304", o_word_valid, o_word);
        end
    endtask

    task automatic test_byte_wins;
        int e0;
        e0 = err_seen;
        exp_words.push_back(32'h31323334);
        strobe(8'h31, 1'b1);
        idle_n(TO - 1);
        strobe(8'h32, 1'b1);
        strobe(8'h33, 1'b1);
        strobe(8'h34, 1'b1);
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b1 || o_word !== 32'h31323334 || err_seen != e0) begin
            errors++;
            $display("FAIL byte_wins got wv=%b word=%08h errs=%0d required 1 31323334 0",
                     o_word_valid, o_word, err_seen - e0);
        end
    endtask
`else
    task automatic test_no_timeout;
        strobe(8'h11, 1'b1);
        strobe(8'h22, 1'b1);
        idle_n(4 * TO);
        checks++;
        if (o_busy !== 1'b1 || err_seen != 0) begin
            errors++;
            $display("FAIL no_timeout_wait got busy=%b errs=%0d required 1 0", o_busy, err_seen);
        end
        exp_words.push_back(32'h11223344);
        strobe(8'h33, 1'b0);
        strobe(8'h44, 1'b0);
        idle_n(1);
        checks++;
        if (o_word_valid !== 1'b1 || o_word !== 32'h11223344) begin
            errors++;
            $display("FAIL no_timeout_word got wv=%b word=%08h required 1 11223344", o_word_valid, o_word);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_pass();
        test_word();
        test_back_to_back();
        test_mode_toggle();
        test_reset_mid_word();
`ifdef B2W_TIMEOUT_EN
        test_timeout();
        test_byte_wins();
`else
        test_no_timeout();
`endif
        idle_n(2);
        checks++;
        if (exp_words.size() != 0 || exp_bytes.size() != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL final_drain got words=%0d bytes=%0d busy=%b required 0 0 0",
                     exp_words.size(), exp_bytes.size(), o_busy);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_to_word_rx.md
BYTE_TO_WORD_RX -- requirements
Module: byte_to_word_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the inter-byte idle limit in sys_clk cycles while a word is partially assembled.
REQ-002 The block SHALL have the following ports:
- sys_clk  in  1  sole clock, rising edge.
- sw_0  in  1  asynchronous active-low reset.
- i_mode_select  in  1  0 = byte pass-through, 1 = 32-bit word assembly.
- i_rx_dv  in  1  one-cycle strobe from the UART receiver, asserted when i_rx_byte is valid.
- i_rx_byte  in  8  received byte.
- o_byte  out  8  last pass-through byte.
- o_byte_valid  out  1  one-cycle pulse, o_byte is new.
- o_word  out  32  last assembled word.
- o_word_valid  out  1  one-cycle pulse, o_word is new.
- o_busy  out  1  high while a word is partially assembled.
- o_timeout_err  out  1  one-cycle pulse, partial word discarded.
REQ-003 The block SHALL use one clock (sys_clk) and an asynchronous, active-low reset (sw_0).

Function
REQ-004 The FSM SHALL have the states S_IDLE and S_COLLECT, with a 2-bit byte index idx.
REQ-005 In S_IDLE, a strobe with i_mode_select=0 SHALL load o_byte and pulse o_byte_valid in the next cycle, with the FSM staying in S_IDLE.
REQ-006 In S_IDLE, a strobe with i_mode_select=1 SHALL store the byte into word bits [31:24], set idx=1, and go to S_COLLECT.
REQ-007 Byte order SHALL be MSB first: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8] and byte 3 to [7:0].
REQ-008 In S_COLLECT, each strobe SHALL store its byte at idx and increment idx.
REQ-009 On the 4th byte (idx=3), o_word SHALL update and o_word_valid SHALL pulse in the next cycle, idx SHALL wrap to 0, and the FSM SHALL return to S_IDLE.
REQ-010 i_mode_select SHALL be sampled only on the first byte; changes during S_COLLECT SHALL be ignored until the word completes or times out.
REQ-011 Latency from i_rx_dv to the valid pulse SHALL be exactly 1 cycle, and no backpressure SHALL exist.
REQ-012 o_byte and o_word SHALL hold their values between pulses.
REQ-013 o_busy SHALL equal (state == S_COLLECT) and SHALL be registered.
REQ-014 The partial word register SHALL NOT be visible on o_word until the word completes.
REQ-015 Strobes on consecutive cycles SHALL each be accepted, with no byte dropped.

Reset
REQ-016 While sw_0=0, all outputs SHALL be 0, the state SHALL be S_IDLE, idx SHALL be 0, the partial word SHALL be 0 and the timeout counter SHALL be 0.
REQ-017 Reset asserted mid-word SHALL discard the partial word immediately, with no o_word_valid and no o_timeout_err.
REQ-018 The first strobe after reset release SHALL be treated as a first byte.

Configuration
REQ-019 With macro B2W_TIMEOUT_EN defined, the block SHALL count cycles in S_COLLECT, clearing the count on each strobe.
REQ-020 With B2W_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the block SHALL pulse o_timeout_err, discard the partial word, set idx=0 and go to S_IDLE.
REQ-021 If a strobe coincides with timeout expiry, the byte SHALL win: it is accepted and no error is raised.
REQ-022 Without B2W_TIMEOUT_EN, no counter SHALL exist, o_timeout_err SHALL be tied to 0, and S_COLLECT SHALL wait indefinitely.

Structure
REQ-023 Package b2w_pkg SHALL hold the state encoding, WORD_BYTES=4, and the timeout counter width function ($clog2(TIMEOUT_CYCLES+1)).
REQ-024 The sub-module b2w_timeout (counter with clear, enable and expire outputs) SHALL be instantiated only under B2W_TIMEOUT_EN.

Verification
REQ-025 Mode 0 with strobe byte 0xAB SHALL produce o_byte=0xAB and a 1-cycle o_byte_valid on the next edge, with o_word_valid staying 0.
REQ-026 Mode 1 with bytes 0x00, 0xFF, 0x12, 0xCD SHALL produce o_word=0x00FF12CD and o_word_valid one cycle after the 4th strobe, with o_busy high from byte 1 to byte 4.
REQ-027 Mode 1 with bytes 0x11 and 0x22 followed by TIMEOUT_CYCLES of idle (macro defined) SHALL produce one o_timeout_err pulse, no o_word_valid, and o_busy low.
REQ-028 After the timeout in REQ-027, bytes 0x01, 0x02, 0x03, 0x04 SHALL produce o_word=0x01020304.
REQ-029 Mode 1 with 2 bytes sent, then sw_0 pulsed low for 1 cycle, SHALL clear all outputs; the following bytes 0xAA, 0xBB, 0xCC, 0xDD SHALL produce o_word=0xAABBCCDD.
REQ-030 i_mode_select toggled to 0 after the first byte of 0xDE, 0xAD, 0xBE, 0xEF SHALL still produce o_word=0xDEADBEEF with no o_byte_valid, and the next byte 0x10 in mode 0 SHALL produce o_byte=0x10.
